// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch block.
//   ROM_ADDR_W : width of the byte address driven to the instruction ROM
//   INSTR_W    : instruction word width
//   PC_STEP    : sequential pc increment
//   ROM_LIMIT  : first byte address outside the ROM window
//   fetch_state_e : fetch FSM states (RUN may issue, FAULT never issues)
package instr_fetch_pkg;

  localparam int          ROM_ADDR_W = 16;
  localparam int          INSTR_W    = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ROM_LIMIT  = 32'h0001_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // A fetch address is usable only if word aligned and inside the ROM window.
  function automatic logic pc_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc[31:ROM_ADDR_W] == '0);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched {instr, pc} records on the decode side.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head (caller only pops when not empty)
//   flush_i      : empty the queue; wins over push/pop in the same cycle
//   head_o       : head record, stable until popped or flushed
//   empty_o      : queue holds no records
//   count_o      : number of records held (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues sequential ROM reads, queues the
// returned words for decode, handles redirects and halts on bad addresses.
//   clk, rst           : clock, synchronous active-high reset
//   rom_addr_o         : byte address to ROM (pc[15:0])
//   rom_addr_valid_o   : request strobe; ROM answers exactly one cycle later
//   rom_instr_i        : ROM read data
//   rom_instr_valid_i  : ROM data valid
//   redirect_i         : branch/jump redirect strobe
//   redirect_pc_i      : redirect target
//   fetch_instr_o      : queue head instruction
//   fetch_pc_o         : queue head address
//   fetch_valid_o      : queue head valid
//   fetch_ready_i      : decode takes the head
//   fault_o            : fetch halted on a bad address
//   fault_pc_o         : offending address while fault_o=1
//   dbg_state_o        : current FSM state (0=RUN, 1=FAULT)
// Handshake: the head transfers on any cycle where fetch_valid_o and
// fetch_ready_i are both 1; while valid and not ready the head holds steady
// and fetch_valid_o does not drop except on redirect or reset.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  output logic                  rom_addr_valid_o,
  input  logic [INSTR_W-1:0]    rom_instr_i,
  input  logic                  rom_instr_valid_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output logic [INSTR_W-1:0]    fetch_instr_o,
  output logic [31:0]           fetch_pc_o,
  output logic                  fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic                  fault_o,
  output logic [31:0]           fault_pc_o,
  output logic                  dbg_state_o
);

  localparam int                CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam int                REC_W   = INSTR_W + 32;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic             inflight_q, inflight_d;
  logic             stale_q, stale_d;

  logic             issue;
  logic             push;
  logic             pop;
  logic             flush;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] occupancy;
  logic [REC_W-1:0] q_head;
  logic [31:0]      pc_next;

  // Credit check counts the outstanding response as an occupied slot, so a
  // response can never land in a full queue. Pops in this cycle are not
  // credited, which keeps the issue decision independent of fetch_ready_i.
  assign occupancy = q_count + CNT_W'(inflight_q);
  assign issue     = !rst && (state_q == ST_RUN) && !redirect_i && (occupancy < DEPTH_C);
  assign flush     = rst || redirect_i;
  // A response belonging to a request issued before a redirect/reset is dropped.
  assign push      = rom_instr_valid_i && inflight_q && !stale_q && !flush;
  assign pop       = fetch_valid_o && fetch_ready_i;
  assign pc_next   = pc_q + PC_STEP;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    fault_pc_d = fault_pc_q;
    inflight_d = issue;
    stale_d    = redirect_i;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
      if (pc_legal(redirect_pc_i)) begin
        state_d    = ST_RUN;
        fault_pc_d = '0;
      end else begin
        state_d    = ST_FAULT;
        fault_pc_d = redirect_pc_i;
      end
    end else if (issue) begin
      pc_d     = pc_next;
      req_pc_d = pc_q;
      // Falling off the end of the ROM halts further issue; the response for
      // the last word is still in flight and is accepted normally.
      if (pc_next == ROM_LIMIT) begin
        state_d    = ST_FAULT;
        fault_pc_d = pc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      fault_pc_q <= '0;
      inflight_q <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      fault_pc_q <= fault_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (REC_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({rom_instr_i, req_pc_q}),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (q_head),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  assign rom_addr_o       = pc_q[ROM_ADDR_W-1:0];
  assign rom_addr_valid_o = issue;
  assign fetch_valid_o    = !q_empty && !rst;
  assign fetch_instr_o    = q_head[REC_W-1:32];
  assign fetch_pc_o       = q_head[31:0];
  assign fault_o          = (state_q == ST_FAULT);
  assign fault_pc_o       = fault_pc_q;
  assign dbg_state_o      = (state_q == ST_FAULT);

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4, is the number of decoded-side queue entries; legal values are powers of two, 2 or more.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rom_addr_o  out  16  byte address to instruction ROM, equal to pc[15:0].
REQ-006 rom_addr_valid_o  out  1  fetch request strobe to ROM.
REQ-007 rom_instr_i  in  32  ROM read data.
REQ-008 rom_instr_valid_i  in  1  ROM data valid, exactly 1 cycle after the request.
REQ-009 redirect_i  in  1  branch/jump redirect strobe.
REQ-010 redirect_pc_i  in  32  redirect target.
REQ-011 fetch_instr_o  out  32  instruction to decode.
REQ-012 fetch_pc_o  out  32  address of fetch_instr_o.
REQ-013 fetch_valid_o  out  1  queue head valid.
REQ-014 fetch_ready_i  in  1  decode accepts the head.
REQ-015 fault_o  out  1  fetch halted on a bad address.
REQ-016 fault_pc_o  out  32  offending address, valid while fault_o=1.

Function
REQ-017 The FSM SHALL have states RUN (issue permitted) and FAULT (no issue).
REQ-018 A request SHALL issue (rom_addr_valid_o=1) iff the state is RUN, redirect_i=0, and occupancy+inflight < QUEUE_DEPTH; it SHALL NOT depend on fetch_ready_i or the ROM inputs.
REQ-019 On issue: pc <= pc+4, inflight <= 1, and req_pc <= pc; without issue, inflight <= 0.
REQ-020 rom_instr_valid_i with inflight=1 and not stale SHALL enqueue {rom_instr_i, req_pc}; rom_instr_valid_i with inflight=0 SHALL be ignored.
REQ-021 Queue: FIFO; fetch_valid_o = not empty; fetch_instr_o/fetch_pc_o = head; pop on fetch_valid_o & fetch_ready_i; head SHALL stay stable while valid & !ready.
REQ-022 Simultaneous push and pop SHALL both take effect; the credit rule (REQ-018) guarantees no push into a full queue.
REQ-023 Redirect has highest priority: queue flushed (empty next cycle), an in-flight response arriving next cycle marked stale and dropped, pc <= redirect_pc_i, no issue in the redirect cycle.
REQ-024 A pop handshake in the redirect cycle SHALL complete at the interface; remaining entries are discarded.
REQ-025 Redirect target with [1:0]!=0 or [31:16]!=0 SHALL enter FAULT: fault_o=1, fault_pc_o=target, no issue.
REQ-026 A valid redirect in FAULT SHALL return to RUN and clear fault_o the next cycle.
REQ-027 If sequential increment makes pc = 32'h0001_0000, the block SHALL enter FAULT with fault_pc_o=32'h0001_0000; already-queued entries still drain normally.
REQ-028 Latency: a redirect sampled at edge N SHALL issue the target in cycle N+1 and present it on fetch_valid_o in cycle N+3; throughput SHALL be 1 instruction/cycle with fetch_ready_i held at 1.

Reset
REQ-029 Under rst: pc=RESET_PC, state RUN, queue empty, inflight=0, stale=0, fault_o=0, fault_pc_o=0, fetch_valid_o=0, rom_addr_valid_o=0.
REQ-030 The first cycle with rst=0 SHALL issue RESET_PC; reset mid-operation SHALL discard all queued and in-flight data, and the response arriving after reset SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the fetch constants: ROM_ADDR_W=16, INSTR_W=32, PC_STEP=4, ROM_LIMIT=32'h0001_0000, and the FSM state enum.
REQ-032 The queue SHALL be a sub-module fetch_queue (parameterised depth/width; push, pop, flush, count).

Verification
REQ-033 Reset release, ready=1, ROM returns addr-derived data -> requests 0x0000, 0x0004, 0x0008 on consecutive cycles; fetch_valid_o first high 2 cycles after release with pc 0x0.
REQ-034 ready=0 for 10 cycles -> exactly QUEUE_DEPTH (4) requests issue, then rom_addr_valid_o=0; release -> pcs 0x0 to 0xC in order with no loss or duplication.
REQ-035 Redirect to 0x0100 while a request is in flight and the queue is non-empty -> the stale response is dropped, the queue is empty, and the next fetch_pc_o is 0x0100 exactly 3 cycles later.
REQ-036 Redirect to 0x0102 -> fault_o=1, fault_pc_o=0x0102, no requests; then redirect to 0x0200 -> RUN, fetch resumes at 0x0200.
REQ-037 Redirect to 0xFFF8 -> fetches 0xFFF8 and 0xFFFC, then fault_o=1 with fault_pc_o=0x0001_0000; both entries still delivered.
REQ-038 rst asserted for 1 cycle with a full queue and a request in flight -> fetch_valid_o=0 next cycle, and the first delivered pc after release is RESET_PC.
